// File: rtl/prbs15_checker_if.sv
// Byte-stream interface of the PRBS15 checker: received data and controls in, lock and error status out.
// The master modport is the side that feeds data; the slave modport is the checker.
interface prbs15_checker_if #(
    parameter int ERR_W = 16
);
    logic             enable;
    logic [7:0]       prbs_in;
    logic             clear_counters;
    logic             locked;
    logic             err_flag;
    logic [ERR_W-1:0] error_count;

    modport master (
        output enable, prbs_in, clear_counters,
        input  locked, err_flag, error_count
    );

    modport slave (
        input  enable, prbs_in, clear_counters,
        output locked, err_flag, error_count
    );
endinterface

// File: rtl/prbs15_checker.sv
// Byte-wide PRBS15 (x^15+x^14+1) checker: self-synchronises from received data, then counts bit errors
// against a free-running reference until a run of errored bytes forces reacquisition.
module prbs15_checker #(
    parameter int LOCK_COUNT = 4,
    parameter int LOSS_COUNT = 4,
    parameter int ERR_W      = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    prbs15_checker_if.slave  bus
);
    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t           state_q, state_d;
    logic [14:0]      h_q, h_d;
    logic [1:0]       fill_q, fill_d;
    logic [3:0]       match_q, match_d;
    logic [3:0]       loss_q, loss_d;
    logic             err_flag_q, err_flag_d;
    logic [ERR_W-1:0] error_count_q, error_count_d;

    logic [7:0]       pred;
    logic [14:0]      h_pred;
    logic [7:0]       diff;
    logic [3:0]       pop;
    logic [ERR_W:0]   sum;
    logic [ERR_W-1:0] sat_count;

    // Eight steps of the recurrence, oldest-bit-first, to predict the next whole byte.
    always_comb begin
        logic [14:0] hv;
        hv   = h_q;
        pred = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            pred[i] = hv[14] ^ hv[13];
            hv      = {hv[13:0], pred[i]};
        end
        h_pred = hv;
    end

    always_comb begin
        diff = bus.prbs_in ^ pred;
        pop  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'd0, diff[i]};
        end
        sum       = {1'b0, error_count_q} + (ERR_W + 1)'(pop);
        sat_count = sum[ERR_W] ? {ERR_W{1'b1}} : sum[ERR_W-1:0];
    end

    always_comb begin
        state_d       = state_q;
        h_d           = h_q;
        fill_d        = fill_q;
        match_d       = match_q;
        loss_d        = loss_q;
        err_flag_d    = 1'b0;
        error_count_d = error_count_q;

        if (bus.enable) begin
            if (state_q == SEARCH) begin
                h_d = {h_q[6:0], bus.prbs_in};
                if (fill_q != 2'd2) begin
                    fill_d = fill_q + 2'd1;
                end else if (diff == 8'h00 && h_q != 15'h0000) begin
                    if (match_q == 4'(LOCK_COUNT - 1)) begin
                        state_d = LOCKED;
                        match_d = 4'd0;
                        loss_d  = 4'd0;
                        h_d     = h_pred;
                    end else begin
                        match_d = match_q + 4'd1;
                    end
                end else begin
                    match_d = 4'd0;
                end
            end else begin
                // Reference keeps running on its own so line errors never pollute it.
                h_d           = h_pred;
                error_count_d = sat_count;
                err_flag_d    = (diff != 8'h00);
                if (diff != 8'h00) begin
                    if (loss_q == 4'(LOSS_COUNT - 1)) begin
                        state_d = SEARCH;
                        fill_d  = 2'd0;
                        match_d = 4'd0;
                        loss_d  = 4'd0;
                        h_d     = {h_q[6:0], bus.prbs_in};
                    end else begin
                        loss_d = loss_q + 4'd1;
                    end
                end else begin
                    loss_d = 4'd0;
                end
            end
        end

        if (bus.clear_counters) begin
            error_count_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= SEARCH;
            h_q           <= 15'h0000;
            fill_q        <= 2'd0;
            match_q       <= 4'd0;
            loss_q        <= 4'd0;
            err_flag_q    <= 1'b0;
            error_count_q <= '0;
        end else begin
            state_q       <= state_d;
            h_q           <= h_d;
            fill_q        <= fill_d;
            match_q       <= match_d;
            loss_q        <= loss_d;
            err_flag_q    <= err_flag_d;
            error_count_q <= error_count_d;
        end
    end

    assign bus.locked      = (state_q == LOCKED);
    assign bus.err_flag    = err_flag_q;
    assign bus.error_count = error_count_q;
endmodule

// File: tb/tb_prbs15_checker.sv
// Scoreboard bench for prbs15_checker: a 16-bit and a 4-bit counter instance see the same stream;
// expectations are queued as bytes are driven and compared one edge later.
module tb_prbs15_checker;
    logic clock = 1'b0;
    logic reset_n = 1'b0;
    always #5 clock = ~clock;

    logic       en  = 1'b0;
    logic [7:0] din = 8'h00;
    logic       clr = 1'b0;

    prbs15_checker_if #(.ERR_W(16)) bus16 ();
    prbs15_checker_if #(.ERR_W(4))  bus4 ();

    assign bus16.enable         = en;
    assign bus16.prbs_in        = din;
    assign bus16.clear_counters = clr;
    assign bus4.enable          = en;
    assign bus4.prbs_in         = din;
    assign bus4.clear_counters  = clr;

    prbs15_checker #(.LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_W(16)) dut16 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus16)
    );

    prbs15_checker #(.LOCK_COUNT(4), .LOSS_COUNT(4), .ERR_W(4)) dut4 (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus4)
    );

    typedef struct {
        logic lk;
        logic ef;
        int   cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   n_txn    = 0;

    // Test-intent state: whether the checker should be locked, and the true error total.
    logic        lk  = 1'b0;
    int          cnt = 0;
    logic [14:0] g   = 15'h0001;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // Reference stream: emits the oldest history bit, appends h[14]^h[13].
    task automatic gen(output logic [7:0] b);
        b = 8'h00;
        for (int i = 0; i < 8; i++) begin
            b = {b[6:0], g[14]};
            g = {g[13:0], g[14] ^ g[13]};
        end
    endtask

    task automatic drive(input logic e, input logic [7:0] d, input logic c, input logic ef);
        exp_t x;
        @(negedge clock);
        en  = e;
        din = d;
        clr = c;
        x.lk  = lk;
        x.ef  = ef;
        x.cnt = cnt;
        sb.push_back(x);
    endtask

    task automatic send(input logic [7:0] mask, input logic c, input logic lk_after);
        logic [7:0] b;
        logic       ef;
        gen(b);
        ef = lk && (mask != 8'h00);
        if (lk && !c) cnt += $countones(mask);
        if (c) cnt = 0;
        lk = lk_after;
        drive(1'b1, b ^ mask, c, ef);
    endtask

    task automatic gap();
        drive(1'b0, 8'($urandom), 1'b0, 1'b0);
    endtask

    // Two fill bytes plus four matches: lock rises on the edge of the sixth byte.
    task automatic acquire(input bit with_gaps);
        for (int i = 1; i <= 6; i++) begin
            if (with_gaps) repeat ($urandom_range(0, 2)) gap();
            send(8'h00, 1'b0, i == 6);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_locked16"}, int'(bus16.locked), 0);
        check_eq({tag, "_err16"}, int'(bus16.err_flag), 0);
        check_eq({tag, "_cnt16"}, int'(bus16.error_count), 0);
        check_eq({tag, "_locked4"}, int'(bus4.locked), 0);
        check_eq({tag, "_err4"}, int'(bus4.err_flag), 0);
        check_eq({tag, "_cnt4"}, int'(bus4.error_count), 0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clock);
        en      = 1'b0;
        clr     = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        @(negedge clock);
        reset_n = 1'b1;
        lk  = 1'b0;
        cnt = 0;
    endtask

    initial begin : monitor
        forever begin
            exp_t e;
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                n_txn++;
                $display("txn %0d: locked=%0d err=%0d cnt16=%0d cnt4=%0d (exp %0d/%0d/%0d)", n_txn,
                         bus16.locked, bus16.err_flag, bus16.error_count, bus4.error_count,
                         e.lk, e.ef, e.cnt);
                check_eq("locked16", int'(bus16.locked), int'(e.lk));
                check_eq("err_flag16", int'(bus16.err_flag), int'(e.ef));
                check_eq("count16", int'(bus16.error_count), sat(e.cnt, 65535));
                check_eq("locked4", int'(bus4.locked), int'(e.lk));
                check_eq("err_flag4", int'(bus4.err_flag), int'(e.ef));
                check_eq("count4", int'(bus4.error_count), sat(e.cnt, 15));
            end
        end
    end

    initial begin : stim
        #1;
        check_reset_outputs("por");
        do_reset("rst0");

        // Stuck-zero input must never lock.
        for (int i = 0; i < 100; i++) drive(1'b1, 8'h00, 1'b0, 1'b0);

        do_reset("rst1");
        g = 15'h0001;
        acquire(1'b0);
        repeat (3) send(8'h00, 1'b0, 1'b1);

        // Single- and multi-bit errors while locked.
        send(8'h01, 1'b0, 1'b1);
        repeat (3) send(8'h00, 1'b0, 1'b1);
        send(8'h07, 1'b0, 1'b1);
        repeat (3) send(8'h00, 1'b0, 1'b1);

        // Four inverted bytes: lock drops on the fourth, then reacquires.
        send(8'hFF, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b1);
        send(8'hFF, 1'b0, 1'b0);
        acquire(1'b0);
        repeat (2) send(8'h00, 1'b0, 1'b1);

        // Acquisition with enable gaps that must freeze everything.
        do_reset("rst2");
        acquire(1'b1);
        repeat (2) gap();

        // Saturation of the 4-bit counter, interleaving clean bytes to stay locked.
        for (int i = 0; i < 20; i++) begin
            send(8'(1 << (i % 8)), 1'b0, 1'b1);
            send(8'h00, 1'b0, 1'b1);
        end
        // Clear wins over a simultaneous errored byte; the flag still pulses.
        send(8'h10, 1'b1, 1'b1);
        send(8'h00, 1'b0, 1'b1);

        // Build up a count of 9, then reset while locked.
        send(8'h01, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        send(8'h0F, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        send(8'h0F, 1'b0, 1'b1);
        send(8'h00, 1'b0, 1'b1);
        do_reset("rst_mid");
        acquire(1'b0);
        send(8'h00, 1'b0, 1'b1);

        @(negedge clock);
        en = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("scoreboard_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
